// File: rtl/msq_pkg.sv
// msq_pkg: shared widths, window helpers and square-word type for the mean-square blocks
package msq_pkg;
  localparam int DIN_DEF = 16;
  localparam longint MAX_SQ = 64'd1 << (2 * DIN_DEF - 2);
  localparam longint MAX_MEAN = MAX_SQ;
  typedef logic [2*DIN_DEF-2:0] sq_word_t;
  function automatic int acc_width(input int din_w, input int log2_n);
    return 2 * din_w - 1 + log2_n;
  endfunction
  function automatic int win_len(input int log2_n);
    return 1 << log2_n;
  endfunction
endpackage

// File: rtl/msq_win_acc_if.sv
// msq_win_acc_if: sample-in / mean-square-out bundle for msq_win_acc
interface msq_win_acc_if #(
  parameter int DIN_WIDTH  = 16,
  parameter int LOG2_N     = 4,
  parameter int DATA_WIDTH = 32
);
  logic                        valid_in;
  logic signed [DIN_WIDTH-1:0] data_i;
  logic                        clear_i;
  logic                        valid_out;
  logic [DATA_WIDTH-1:0]       data_o;
  logic [LOG2_N:0]             fill_o;
  modport master (output valid_in, data_i, clear_i, input valid_out, data_o, fill_o);
  modport slave  (input valid_in, data_i, clear_i, output valid_out, data_o, fill_o);
endinterface

// File: rtl/msq_win_acc_sq_stage.sv
// sq_stage: registered signed squarer (capture, then square) with valid passthrough and clear flush
module sq_stage #(
  parameter int DIN_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clear,
  input  logic                        i_valid,
  input  logic signed [DIN_WIDTH-1:0] i_data,
  output logic                        o_valid,
  output logic [2*DIN_WIDTH-2:0]      o_sq
);
  logic signed [DIN_WIDTH-1:0]   r_x;
  logic                          r_v0;
  logic signed [2*DIN_WIDTH-1:0] w_prod;
  // a square is never negative, so the sign bit of the product is always zero
  assign w_prod = r_x * r_x;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_v0    <= 1'b0;
      o_sq    <= '0;
      o_valid <= 1'b0;
    end else begin
      r_x     <= i_data;
      r_v0    <= i_valid & ~i_clear;
      o_sq    <= w_prod[2*DIN_WIDTH-2:0];
      o_valid <= r_v0 & ~i_clear;
    end
  end
endmodule

// File: rtl/msq_win_acc.sv
// msq_win_acc: windowed mean of squared samples, feeding sqrt_u32 to produce per-window RMS.
// Define MSQ_ROUND_EN for round-half-up of the mean instead of truncation.
module msq_win_acc
  import msq_pkg::*;
#(
  parameter int DIN_WIDTH  = 16,
  parameter int LOG2_N     = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  msq_win_acc_if.slave bus
);
  localparam int ACC_WIDTH = acc_width(DIN_WIDTH, LOG2_N);
  localparam int SW = 2 * DIN_WIDTH - 1;
`ifdef MSQ_ROUND_EN
  localparam int RND = win_len(LOG2_N) / 2;
`else
  localparam int RND = 0;
`endif
  logic                 w_v1;
  logic [SW-1:0]        w_sq;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LOG2_N:0]      r_cnt;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_last;
  sq_stage #(.DIN_WIDTH(DIN_WIDTH)) u_sq (
    .clk     (clk),
    .rst     (rst),
    .i_clear (bus.clear_i),
    .i_valid (bus.valid_in),
    .i_data  (bus.data_i),
    .o_valid (w_v1),
    .o_sq    (w_sq)
  );
  assign w_sum  = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(w_sq) + (ACC_WIDTH+1)'(RND);
  assign w_last = w_v1 && r_cnt == (LOG2_N+1)'(win_len(LOG2_N) - 1);
  assign bus.fill_o = r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc         <= '0;
      r_cnt         <= '0;
      bus.valid_out <= 1'b0;
      bus.data_o    <= '0;
    end else if (bus.clear_i) begin
      r_acc         <= '0;
      r_cnt         <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      bus.valid_out <= w_last;
      if (w_v1) begin
        r_acc <= w_last ? '0 : r_acc + ACC_WIDTH'(w_sq);
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (w_last) bus.data_o <= DATA_WIDTH'(w_sum >> LOG2_N);
    end
  end
endmodule

// File: tb/tb_msq_win_acc.sv
// tb_msq_win_acc: table-driven windows plus clear/back-to-back/reset sequences, scoreboarded on valid_out
module tb_msq_win_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  typedef struct { int a; int b; bit gap; int exp; } vec_t;
  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t q[$];
  vec_t vecs[4];
  msq_win_acc_if #(.DIN_WIDTH(16), .LOG2_N(4), .DATA_WIDTH(32)) bus ();
  msq_win_acc #(.DIN_WIDTH(16), .LOG2_N(4), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got data_o=%0d expected no pulse", bus.data_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("data_o", bus.data_o, e.data);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end
  task automatic send(input int x);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b1;
    bus.data_i   = 16'(x);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
    end
  endtask
  task automatic window(input int a, input int b, input bit gap, input int exp);
    for (int i = 0; i < 16; i++) begin
      send(i % 2 ? b : a);
      if (i == 15) q.push_back('{32'(exp), cyc + 3});
      if (gap) idle(1);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{16, 16, 1'b0, 256};
    vecs[1] = '{-32768, -32768, 1'b0, 32'h4000_0000};
`ifdef MSQ_ROUND_EN
    vecs[2] = '{255, 0, 1'b0, 32513};
`else
    vecs[2] = '{255, 0, 1'b0, 32512};
`endif
    vecs[3] = '{3, 3, 1'b1, 9};
    bus.valid_in = 1'b0;
    bus.data_i   = '0;
    bus.clear_i  = 1'b0;
    #3;
    chk("rst_valid_out", 32'(bus.valid_out), 0);
    chk("rst_data_o", bus.data_o, 0);
    chk("rst_fill_o", 32'(bus.fill_o), 0);
    #19 rst = 1'b0;
    for (int v = 0; v < 4; v++) begin
      window(vecs[v].a, vecs[v].b, vecs[v].gap, vecs[v].exp);
      idle(4);
      chk("fill_after_window", 32'(bus.fill_o), 0);
    end
    for (int i = 0; i < 10; i++) send(100);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.clear_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_i = 1'b0;
    idle(3);
    chk("fill_after_clear", 32'(bus.fill_o), 0);
    window(1, 1, 1'b0, 1);
    idle(4);
    window(5, 5, 1'b0, 25);
    window(7, 7, 1'b0, 49);
    idle(4);
    for (int i = 0; i < 8; i++) send(2);
    idle(3);
    chk("fill_mid_window", 32'(bus.fill_o), 8);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data_o", bus.data_o, 0);
    chk("async_rst_fill_o", 32'(bus.fill_o), 0);
    chk("async_rst_valid_out", 32'(bus.valid_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    window(2, 2, 1'b0, 4);
    idle(5);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
